// File: rtl/pixel_clip_fifo_if.sv
// Pixel plot stream between the drawers and the clip FIFO, plus the FIFO's
// ready/valid drain side towards the framebuffer write port.
interface pixel_clip_fifo_if;
   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] in_colour;
   logic       in_plot;
   logic       in_ready;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   logic       out_plot;
   logic       out_ready;

   modport master (
      output in_x, in_y, in_colour, in_plot, out_ready,
      input  in_ready, out_x, out_y, out_colour, out_plot
   );

   modport slave (
      input  in_x, in_y, in_colour, in_plot, out_ready,
      output in_ready, out_x, out_y, out_colour, out_plot
   );
endinterface

// File: rtl/pixel_clip_fifo.sv
// Clips plot requests to the visible area and buffers survivors in a small FIFO.
// Optional feature macro: PIXEL_CLIP_STATS_EN enables the clipped-pixel counter.
module pixel_clip_fifo #(
   parameter int DEPTH = 8,
   parameter int XMAX  = 160,
   parameter int YMAX  = 120
) (
   input  logic              clk,
   input  logic              rst,
   pixel_clip_fifo_if.slave  pix,
   output logic              overflow,
   output logic              empty,
   output logic [15:0]       clipped_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = 18;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

   state_t        state;
   logic [AW:0]   count_reg, count_next;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic          overflow_reg;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] head;
   logic          in_range, push, pop, drop;

   assign in_range = (32'(pix.in_x) < XMAX) && (32'(pix.in_y) < YMAX);

   always_comb begin
      state = ST_PARTIAL;
      if (count_reg == '0)
         state = ST_EMPTY;
      else if (count_reg == FULL_COUNT)
         state = ST_FULL;
   end

   // Readiness comes from held occupancy only, so a pop never frees a slot
   // for a push in the same cycle.
   assign pix.in_ready = (state != ST_FULL);
   assign pix.out_plot = (state != ST_EMPTY);
   assign empty        = (state == ST_EMPTY);
   assign overflow     = overflow_reg;

   assign push = pix.in_plot && in_range && pix.in_ready;
   assign drop = pix.in_plot && in_range && !pix.in_ready;
   assign pop  = pix.out_plot && pix.out_ready;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= {pix.in_x, pix.in_y, pix.in_colour};
   end

   assign head = mem[rd_ptr_reg];
   assign {pix.out_x, pix.out_y, pix.out_colour} = empty ? '0 : head;

`ifdef PIXEL_CLIP_STATS_EN
   logic [15:0] clipped_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         clipped_count_reg <= '0;
      else if (pix.in_plot && !in_range && clipped_count_reg != 16'hFFFF)
         clipped_count_reg <= clipped_count_reg + 16'd1;
   end

   assign clipped_count = clipped_count_reg;
`else
   assign clipped_count = 16'd0;
`endif
endmodule
